// File: rtl/uart_pkg.sv
// Shared defaults and the baud-divider computation for the UART sampler.
package uart_pkg;

   localparam int CLK_FREQ_DEFAULT   = 25_000_000;
   localparam int BAUD_RATE_DEFAULT  = 115_200;
   localparam int SIPO_WIDTH_DEFAULT = 8;

   // Clock cycles per baud period, truncated.
   function automatic int calc_div(input int clk_freq, input int baud_rate);
      return clk_freq / baud_rate;
   endfunction

endpackage

// File: rtl/uart_sampler_baud_tick_gen.sv
// Free-running baud divider: one-cycle tick every DIV clocks.
module baud_tick_gen
   import uart_pkg::*;
#(
   parameter int CLK_FREQ  = CLK_FREQ_DEFAULT,
   parameter int BAUD_RATE = BAUD_RATE_DEFAULT
) (
   input  logic clk_25mhz,
   input  logic reset,
   output logic tick
);

   localparam int DIV = calc_div(CLK_FREQ, BAUD_RATE);
   localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(DIV - 1);

   logic [CW-1:0] cnt;

   always_ff @(posedge clk_25mhz) begin
      if (reset)
         cnt <= '0;
      else if (cnt == LAST)
         cnt <= '0;
      else
         cnt <= cnt + 1'b1;
   end

   // Gated so nothing downstream sees a tick while reset is held.
   assign tick = (cnt == LAST) && !reset;

endmodule

// File: rtl/uart_sampler.sv
// Samples the RX line once per baud period into a SIPO register; exposes the
// four newest samples and a one-cycle strobe when a new sample lands.
module uart_sampler
   import uart_pkg::*;
#(
   parameter int CLK_FREQ   = CLK_FREQ_DEFAULT,
   parameter int BAUD_RATE  = BAUD_RATE_DEFAULT,
   parameter int SIPO_WIDTH = SIPO_WIDTH_DEFAULT
) (
   input  logic       clk_25mhz,
   input  logic       reset,
   input  logic       rx_data,
   output logic [3:0] last_4_bits,
   output logic       sample_tick
);

   logic                  sync1, sync2;
   logic                  rx_sync;
   logic                  tick_int;
   logic [SIPO_WIDTH-1:0] sr;

   baud_tick_gen #(
      .CLK_FREQ  (CLK_FREQ),
      .BAUD_RATE (BAUD_RATE)
   ) u_tick (
      .clk_25mhz (clk_25mhz),
      .reset     (reset),
      .tick      (tick_int)
   );

   // Synchronizer idles high to match the line's idle level.
   always_ff @(posedge clk_25mhz) begin
      if (reset) begin
         sync1 <= 1'b1;
         sync2 <= 1'b1;
      end else begin
         sync1 <= rx_data;
         sync2 <= sync1;
      end
   end

   assign rx_sync = sync2;

   always_ff @(posedge clk_25mhz) begin
      if (reset) begin
         sr          <= '1;
         sample_tick <= 1'b0;
      end else begin
         sample_tick <= tick_int;
         if (tick_int)
            sr <= {sr[SIPO_WIDTH-2:0], rx_sync};
      end
   end

   assign last_4_bits = sr[3:0];

   // The oldest sample only falls off the end of the register.
   logic unused_sr_msb;
   assign unused_sr_msb = sr[SIPO_WIDTH-1];

endmodule

// File: tb/tb_uart_sampler.sv
// Randomized bench for uart_sampler against a cycle-count reference model.
module tb_uart_sampler;

   localparam int DIV = 25_000_000 / 115_200;

   logic       clk_25mhz = 1'b0;
   logic       reset     = 1'b1;
   logic       rx_data   = 1'b1;
   logic [3:0] last_4_bits;
   logic       sample_tick;

   int checks   = 0;
   int failures = 0;

   // Reference model: line history for the two-clock delay, edges since reset.
   logic       h1 = 1'b1, h2 = 1'b1;
   int         n  = 0;
   logic [3:0] m4 = 4'hF;
   logic       mtick = 1'b0;

   uart_sampler dut (
      .clk_25mhz   (clk_25mhz),
      .reset       (reset),
      .rx_data     (rx_data),
      .last_4_bits (last_4_bits),
      .sample_tick (sample_tick)
   );

   always #20 clk_25mhz = ~clk_25mhz;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // One clock: advance the model with the inputs present at the edge, then compare.
   task automatic step();
      @(posedge clk_25mhz);
      if (reset) begin
         h1 = 1'b1; h2 = 1'b1; n = 0; m4 = 4'hF; mtick = 1'b0;
      end else begin
         n++;
         mtick = ((n % DIV) == 0);
         if (mtick) m4 = {m4[2:0], h2};
         h2 = h1;
         h1 = rx_data;
      end
      #1;
      chk("model_l4", 32'(last_4_bits), 32'(m4));
      chk("model_tick", 32'(sample_tick), 32'(mtick));
   endtask

   task automatic wait_tick(output int k);
      k = 0;
      while (!sample_tick && k < 1000) begin
         step();
         k++;
      end
   endtask

   initial begin
      int k, lat, last_t;
      logic prev;
      logic pat [4] = '{1'b1, 1'b0, 1'b1, 1'b1};

      repeat (10) begin
         step();
         chk("rst_l4", 32'(last_4_bits), 32'hF);
         chk("rst_tick", 32'(sample_tick), 32'h0);
      end
      reset = 1'b0;
      wait_tick(k);
      chk("first_tick", k, DIV);

      rx_data = 1'b1;
      repeat (8*DIV + 100) step();
      chk("hold1", 32'(last_4_bits), 32'hF);

      rx_data = 1'b0;
      lat = 0;
      while (last_4_bits[0] && lat < 300) begin
         step();
         lat++;
      end
      chk("fall_latency", 32'(lat >= 3 && lat <= DIV + 2), 32'h1);
      repeat (8*DIV + 100 - lat) step();
      chk("hold0", 32'(last_4_bits), 32'h0);

      last_t = -1;
      prev = 1'b0;
      for (int i = 0; i < 2000; i++) begin
         rx_data = 1'($urandom_range(0, 1));
         step();
         if (prev) chk("tick_width", 32'(sample_tick), 32'h0);
         if (sample_tick) begin
            if (last_t >= 0) chk("tick_spacing", i - last_t, DIV);
            last_t = i;
         end
         prev = sample_tick;
      end

      wait_tick(k);
      chk("pat_sync", 32'(sample_tick), 32'h1);
      repeat (DIV/2) step();
      for (int w = 0; w < 4; w++) begin
         rx_data = pat[w];
         repeat (DIV) step();
      end
      chk("pattern", 32'(last_4_bits), 32'hB);

      rx_data = 1'b0;
      repeat (4*DIV + 10) step();
      chk("pre_rst", 32'(last_4_bits), 32'h0);
      wait_tick(k);
      repeat (DIV/2) step();
      reset = 1'b1;
      step();
      chk("mid_rst_l4", 32'(last_4_bits), 32'hF);
      chk("mid_rst_tick", 32'(sample_tick), 32'h0);
      reset = 1'b0;
      wait_tick(k);
      chk("post_rst_tick", k, DIV);

      // Random line activity with occasional short resets.
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 3) == 0) rx_data = 1'($urandom_range(0, 1));
         reset = ($urandom_range(0, 299) == 0);
         step();
      end
      reset = 1'b0;
      repeat (2*DIV) step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
